// File: rtl/e_mdu_param_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and small decode helpers used by the datapath and the control.
package e_mdu_param_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_MULT_LAT = 5;
    localparam int DEFAULT_DIV_LAT  = 10;
    localparam int MDU_OP_W         = 4;

    typedef enum logic [MDU_OP_W-1:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_MUL  = 2'd1,
        CLS_DIV  = 2'd2,
        CLS_MOVE = 2'd3
    } op_class_e;

    // Unused encodings fall into CLS_NONE so they behave exactly like OP_NONE.
    function automatic op_class_e op_class(input logic [MDU_OP_W-1:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return CLS_MUL;
            OP_DIV, OP_DIVU:                                        return CLS_DIV;
            OP_MTHI, OP_MTLO:                                       return CLS_MOVE;
            default:                                                return CLS_NONE;
        endcase
    endfunction

    function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/e_mdu_param_arith.sv
// Purely combinational result generator: given the op, operands and the
// current HI/LO it produces the values HI/LO should take once the op retires.
module mdu_arith
    import e_mdu_param_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [WIDTH-1:0]    hi,
    input  logic [WIDTH-1:0]    lo,
    output logic [WIDTH-1:0]    hi_next,
    output logic [WIDTH-1:0]    lo_next
);

    localparam int DW = 2 * WIDTH;

    logic             sgn;
    logic [DW-1:0]    a_ext;
    logic [DW-1:0]    b_ext;
    logic [DW-1:0]    product;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    mac_sum;
    logic [DW-1:0]    mac_diff;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_zero;
    logic             div_ovf;

    assign sgn = is_signed_op(op);

    // A 2W-bit unsigned multiply of the sign-extended operands gives the exact
    // signed product modulo 2^(2W), so one multiplier serves both signednesses.
    assign a_ext    = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign b_ext    = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign product  = a_ext * b_ext;
    assign acc      = {hi, lo};
    assign mac_sum  = acc + product;
    assign mac_diff = acc - product;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend.
    assign a_neg    = sgn & a[WIDTH-1];
    assign b_neg    = sgn & b[WIDTH-1];
    assign a_mag    = a_neg ? (~a + 1'b1) : a;
    assign b_mag    = b_neg ? (~b + 1'b1) : b;
    assign div_zero = (b == '0);
    assign b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag    = a_mag / b_safe;
    assign r_mag    = a_mag % b_safe;
    assign quot     = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    assign rem      = a_neg ? (~r_mag + 1'b1) : r_mag;
    assign div_ovf  = sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    always_comb begin
        hi_next = hi;
        lo_next = lo;
        case (op)
            OP_MULT, OP_MULTU: begin
                hi_next = product[DW-1:WIDTH];
                lo_next = product[WIDTH-1:0];
            end
            OP_MADD, OP_MADDU: begin
                hi_next = mac_sum[DW-1:WIDTH];
                lo_next = mac_sum[WIDTH-1:0];
            end
            OP_MSUB, OP_MSUBU: begin
                hi_next = mac_diff[DW-1:WIDTH];
                lo_next = mac_diff[WIDTH-1:0];
            end
            OP_DIV, OP_DIVU: begin
                if (div_zero) begin
                    hi_next = a;
                    lo_next = '1;
                end else if (div_ovf) begin
                    hi_next = '0;
                    lo_next = a;
                end else begin
                    hi_next = rem;
                    lo_next = quot;
                end
            end
            default: begin
                hi_next = hi;
                lo_next = lo;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu_param.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. Results are
// computed at launch, parked in a shadow register and committed when the
// latency counter expires, so HI/LO stay frozen while Busy is high.
module e_mdu_param
    import e_mdu_param_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MULT_LAT = DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = DEFAULT_DIV_LAT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Start,
    input  logic                Flush,
    input  logic [MDU_OP_W-1:0] MDUOp,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic                Busy,
    output logic [WIDTH-1:0]    HI,
    output logic [WIDTH-1:0]    LO
);

    localparam int MAX_LAT = max_int(MULT_LAT, DIV_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic [WIDTH-1:0] hi_reg,        hi_next;
    logic [WIDTH-1:0] lo_reg,        lo_next;
    logic [WIDTH-1:0] shadow_hi_reg, shadow_hi_next;
    logic [WIDTH-1:0] shadow_lo_reg, shadow_lo_next;

    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;
    op_class_e        op_cls;
    logic             busy;
    logic             accept;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op      (MDUOp),
        .a       (A),
        .b       (B),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .hi_next (arith_hi),
        .lo_next (arith_lo)
    );

    assign op_cls = op_class(MDUOp);
    assign busy   = (cnt_reg != '0);
    assign accept = Start && !busy && ((op_cls == CLS_MUL) || (op_cls == CLS_DIV));

    // Priority: Flush, then an in-flight op, then idle-time launch or move.
    always_comb begin
        cnt_next       = cnt_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        shadow_hi_next = shadow_hi_reg;
        shadow_lo_next = shadow_lo_reg;
        if (Flush) begin
            cnt_next       = '0;
            shadow_hi_next = '0;
            shadow_lo_next = '0;
        end else if (busy) begin
            cnt_next = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) begin
                hi_next = shadow_hi_reg;
                lo_next = shadow_lo_reg;
            end
        end else if (accept) begin
            shadow_hi_next = arith_hi;
            shadow_lo_next = arith_lo;
            cnt_next       = (op_cls == CLS_DIV) ? DIV_CNT : MULT_CNT;
        end else if (MDUOp == OP_MTHI) begin
            hi_next = A;
        end else if (MDUOp == OP_MTLO) begin
            lo_next = A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg       <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            shadow_hi_reg <= '0;
            shadow_lo_reg <= '0;
        end else begin
            cnt_reg       <= cnt_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            shadow_hi_reg <= shadow_hi_next;
            shadow_lo_reg <= shadow_lo_next;
        end
    end

    assign Busy = busy;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_e_mdu_param.sv
// Scoreboard bench for e_mdu_param: the driver queues hand-computed HI/LO and
// Busy-window lengths; a monitor checks them each time Busy drops.
module tb_e_mdu_param;
    import e_mdu_param_pkg::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic        Flush;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    e_mdu_param #(
        .WIDTH    (32),
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .Flush (Flush),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Monitor: measure each Busy window, verify HI/LO are frozen inside it,
    // then compare the committed (or preserved) result on the falling edge.
    logic        prev_busy = 1'b0;
    logic        stable_ok;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    int          busy_cnt;

    always @(negedge clk) begin
        exp_t e;
        if (Busy === 1'b1) begin
            if (!prev_busy) begin
                hold_hi   = HI;
                hold_lo   = LO;
                stable_ok = 1'b1;
                busy_cnt  = 0;
            end
            busy_cnt++;
            if (HI !== hold_hi || LO !== hold_lo) stable_ok = 1'b0;
            prev_busy = 1'b1;
        end else begin
            if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion actual=HI:%h LO:%h required=no op", HI, LO);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_hi"}, HI, e.hi);
                    chk({e.name, "_lo"}, LO, e.lo);
                    chk({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
                    chk({e.name, "_frozen_while_busy"}, {31'd0, stable_ok}, 32'd1);
                end
            end
            prev_busy = 1'b0;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = OP_NONE;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (Busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (Busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy after 40 cycles required=idle", name);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                          input string name);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.lat = lat; e.name = name;
        sb_q.push_back(e);
        issue(op, a, b);
        wait_idle(name);
    endtask

    // Launch an op, then assert Flush (or reset) so it is sampled at the k-th
    // edge after the accepting edge; optionally poke Start+Mthi while busy.
    task automatic run_abort(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int k, input bit use_reset, input bit poke,
                             input logic [31:0] ehi, input logic [31:0] elo, input string name);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.lat = k; e.name = name;
        sb_q.push_back(e);
        issue(op, a, b);
        if (poke) begin
            Start = 1'b1;
            MDUOp = OP_MTHI;
            A     = 32'hDEAD_BEEF;
        end
        for (int i = 1; i < k; i++) begin
            @(negedge clk);
            Start = 1'b0;
            MDUOp = OP_NONE;
        end
        if (use_reset) reset = 1'b1;
        else           Flush = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        Flush = 1'b0;
        wait_idle(name);
    endtask

    task automatic idle_poke(input logic start, input logic flush, input logic [3:0] op,
                             input logic [31:0] a);
        @(negedge clk);
        Start = start;
        Flush = flush;
        MDUOp = op;
        A     = a;
        B     = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        Flush = 1'b0;
        MDUOp = OP_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        Start = 1'b1;
        Flush = 1'b0;
        MDUOp = OP_MULT;
        A     = 32'd7;
        B     = 32'd7;
        repeat (3) @(negedge clk);
        chk("reset_hi",   HI, 32'h0);
        chk("reset_lo",   LO, 32'h0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        reset = 1'b0;
        Start = 1'b0;
        MDUOp = OP_NONE;
        A     = 32'd0;
        B     = 32'd0;

        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 5,  "mult_neg");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5,  "multu_max");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg");
        run_op(OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         10, "divu");
        run_op(OP_DIV,   32'h12,        32'd0,        32'h12,        32'hFFFF_FFFF, 10, "div_zero");
        run_op(OP_DIVU,  32'h12,        32'd0,        32'h12,        32'hFFFF_FFFF, 10, "divu_zero");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 10, "div_ovf");

        idle_poke(1'b0, 1'b0, OP_MTLO, 32'hFFFF_FFFF);
        chk("mtlo_lo", LO, 32'hFFFF_FFFF);
        idle_poke(1'b0, 1'b0, OP_MTHI, 32'h0);
        chk("mthi_hi", HI, 32'h0);

        run_op(OP_MADDU, 32'd1,         32'd1,         32'd1,         32'h0,         5, "maddu");
        run_op(OP_MSUB,  32'd1,         32'd1,         32'd0,         32'hFFFF_FFFF, 5, "msub");
        run_op(OP_MADD,  32'hFFFF_FFFF, 32'd2,         32'd0,         32'hFFFF_FFFD, 5, "madd_neg");
        run_op(OP_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFC, 5, "msubu_max");

        run_abort(OP_MULT, 32'd3, 32'd3, 3, 1'b0, 1'b1, 32'd2, 32'hFFFF_FFFC, "flush_mid");
        run_abort(OP_MULT, 32'd3, 32'd3, 5, 1'b0, 1'b0, 32'd2, 32'hFFFF_FFFC, "flush_last");

        idle_poke(1'b1, 1'b0, OP_NONE, 32'd3);
        chk("none_busy", {31'd0, Busy}, 32'd0);
        idle_poke(1'b1, 1'b0, 4'hF, 32'd3);
        chk("unused_busy", {31'd0, Busy}, 32'd0);
        chk("unused_lo", LO, 32'hFFFF_FFFC);
        idle_poke(1'b1, 1'b1, OP_MULT, 32'd3);
        chk("start_flush_busy", {31'd0, Busy}, 32'd0);
        idle_poke(1'b0, 1'b1, OP_MTHI, 32'h55);
        chk("mthi_flush_hi", HI, 32'd2);

        run_abort(OP_DIV, 32'd100, 32'd7, 4, 1'b1, 1'b0, 32'd0, 32'd0, "reset_mid_div");
        repeat (12) @(negedge clk);
        chk("no_late_commit_hi", HI, 32'd0);
        chk("no_late_commit_lo", LO, 32'd0);

        run_op(OP_MULT, 32'd3, 32'd3, 32'd0, 32'd9, 5, "mult_after_reset");

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e_mdu_param.md
E_MDU_PARAM -- requirements
Module: e_mdu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MULT_LAT, default 5, multiply/accumulate latency in cycles, range 1..15.
REQ-003 SHALL have parameter DIV_LAT, default 10, divide latency in cycles, range 1..15.
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Start  input  1  launches the arithmetic op on MDUOp.
REQ-007 SHALL have port Flush  input  1  cancels any in-flight op (exception/flush from pipeline).
REQ-008 SHALL have port MDUOp  input  4  operation select.
REQ-009 SHALL have port A  input  WIDTH  rs operand.
REQ-010 SHALL have port B  input  WIDTH  rt operand.
REQ-011 SHALL have port Busy  output  1  op in flight, to hazard unit.
REQ-012 SHALL have port HI  output  WIDTH  architectural HI register.
REQ-013 SHALL have port LO  output  WIDTH  architectural LO register.

Function
REQ-014 SHALL support ops None, Mult, Multu, Div, Divu, Mthi, Mtlo, Madd, Maddu, Msub, Msubu.
REQ-015 SHALL accept an arithmetic op only at an edge with Start=1, Busy=0, Flush=0, reset=0; otherwise Start SHALL be ignored, no state change.
REQ-016 SHALL, on accept, compute the result from A, B and current HI/LO, hold it in a shadow register, load the counter with MULT_LAT (Mult/Multu/Madd/Maddu/Msub/Msubu) or DIV_LAT (Div/Divu).
REQ-017 SHALL hold Busy=1 for exactly LAT cycles after the accepting edge; Busy is a registered signal (counter != 0).
REQ-018 SHALL write the shadow result to HI/LO at the same rising edge where the counter goes 1->0; HI/LO SHALL not change during Busy; no negedge or Busy-edge triggered logic.
REQ-019 SHALL compute Mult/Multu as the full 2*WIDTH signed/unsigned product, {HI,LO}=product.
REQ-020 SHALL compute Madd(u)/Msub(u) as {HI,LO} +/- product, modulo 2^(2*WIDTH), signedness per op.
REQ-021 SHALL compute Div/Divu as LO=quotient truncated toward zero, HI=remainder with sign of dividend.
REQ-022 SHALL, on divide by zero, produce HI=A, LO=all ones (both signednesses), same latency.
REQ-023 SHALL, on signed Div of most-negative by -1, produce LO=most-negative, HI=0.
REQ-024 SHALL execute Mthi (HI<=A) / Mtlo (LO<=A) at any edge with Busy=0, Flush=0, independent of Start; ignored while Busy=1.
REQ-025 SHALL, on Flush=1, clear the counter (Busy=0 next cycle), discard the shadow result, leave HI/LO unchanged; Flush wins over Start and Mthi/Mtlo in the same cycle.
REQ-026 SHALL treat Flush at the completing edge (counter=1) as winning: result discarded.
REQ-027 SHALL treat MDUOp=None or unused encodings with Start=1 as no-op, Busy stays 0.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, set HI=0, LO=0, shadow=0, counter=0 (Busy=0), regardless of any in-flight op or other inputs.

Structure
REQ-029 SHALL take MDUOp encodings from shared macros.v: None=0, Mult=1, Multu=2, Div=3, Divu=4, Mthi=5, Mtlo=6, Madd=7, Maddu=8, Msub=9, Msubu=10; default latencies also defined there.
REQ-030 SHALL place result computation in one combinational sub-module mdu_arith (WIDTH param; inputs op, A, B, HI, LO; outputs next HI/LO); counter, shadow and commit stay in e_mdu_param.
REQ-031 SHALL size the counter to $clog2(max(MULT_LAT,DIV_LAT)+1) bits.

Verification
REQ-032 Mult A=0xFFFFFFFD, B=5, Start one cycle -> Busy=1 exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; HI/LO unchanged while Busy.
REQ-033 Div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFD; Divu A=7, B=2 -> HI=1, LO=3.
REQ-034 Div A=0x12, B=0 -> HI=0x12, LO=0xFFFFFFFF; Div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 Mtlo A=0xFFFFFFFF, Mthi A=0, then Maddu A=1, B=1 -> after 5 cycles HI=1, LO=0; Msub A=1, B=1 -> HI=0, LO=0xFFFFFFFF.
REQ-036 Mult launched, Flush at cycle 3 -> Busy=0 next cycle, HI/LO keep prior values; Start/Mthi asserted during Busy -> ignored.
REQ-037 Div launched, reset at cycle 4 -> next cycle HI=0, LO=0, Busy=0; no later commit.
